pc_stack: RTL and testbench

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_stack_if.sv | 43 ++++
 rtl/pc_stack.sv | 116 +++++++++++
 tb/tb_pc_stack.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pc_stack_if.sv
// pc_stack_if -- control/status bundle for the pc_stack program counter.
//
// The master side (the sequencer driving the PC) issues the per-cycle
// commands and the jump/call target. The slave side (pc_stack) returns
// the registered PC, the stack pointer and the status/error flags.
//
// Signals:
//   pcen, load, call, ret, clr_err  master -> slave  one-cycle commands
//   in_addr  [AW-1:0]               master -> slave  jump/call target
//   a        [AW-1:0]               slave -> master  current PC (registered)
//   halt                            slave -> master  a is all ones
//   sp       [SPW-1:0]              slave -> master  valid stack entries
//   full, empty                     slave -> master  sp == DEPTH / sp == 0
//   ovf, unf                        slave -> master  sticky push-when-full / pop-when-empty
interface pc_stack_if #(
  parameter int AW  = 8,
  parameter int SPW = 3
);
  logic          pcen;
  logic          load;
  logic          call;
  logic          ret;
  logic          clr_err;
  logic [AW-1:0] in_addr;

  logic [AW-1:0]  a;
  logic           halt;
  logic [SPW-1:0] sp;
  logic           full;
  logic           empty;
  logic           ovf;
  logic           unf;

  modport master (
    output pcen, load, call, ret, clr_err, in_addr,
    input  a, halt, sp, full, empty, ovf, unf
  );

  modport slave (
    input  pcen, load, call, ret, clr_err, in_addr,
    output a, halt, sp, full, empty, ovf, unf
  );
endinterface

// File: rtl/pc_stack.sv
// pc_stack -- saturating program counter with a return-address stack.
//
// One PC operation per cycle, priority reset > ret > call > load > pcen > hold.
// call pushes (a+1) mod 2^AW and jumps to in_addr; ret pops into the PC.
// The counter saturates at all ones instead of wrapping. Overflow (call
// while full) and underflow (ret while empty) set sticky flags that
// clr_err clears; a flag being set in the same cycle beats the clear.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (PC, SP and flags only)
//   bus    pc_stack_if.slave: commands in, a/halt/sp/full/empty/ovf/unf out
module pc_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  pc_stack_if.slave   bus
);

  // Index width for the storage array; padded to a power of two so any
  // IW-bit index is in range. Entries at or above DEPTH are never written.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  a_q, a_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           push;

  logic [AW-1:0]  stack_q [2**IW];
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  top_idx;
  logic           halt;
  logic           full;
  logic           empty;

  assign halt     = &a_q;
  assign full     = (sp_q == SPW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign push_idx = IW'(sp_q);
  assign top_idx  = IW'(sp_q - SPW'(1));

  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    a_d   = a_q;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;

    // Clear first so a flag set further down in this cycle wins.
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (bus.ret) begin
      // A concurrent call is ignored entirely: no push, no flag.
      if (!empty) begin
        a_d  = stack_q[top_idx];
        sp_d = sp_q - SPW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (bus.call) begin
      if (!full) begin
        push = 1'b1;
        sp_d = sp_q + SPW'(1);
        a_d  = bus.in_addr;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (bus.load) begin
      a_d = bus.in_addr;
    end else if (bus.pcen && !halt) begin
      a_d = a_q + AW'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // NOTE: the stack storage has no reset; entries at or above sp are never
  // read, so their power-up contents are irrelevant.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack_q[push_idx] <= a_q + AW'(1);
    end
  end

  assign bus.a     = a_q;
  assign bus.halt  = halt;
  assign bus.sp    = sp_q;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack -- directed, self-checking bench for pc_stack (AW=8, DEPTH=4).
// A table of {command, expected state} vectors covers counting, saturation,
// jumps and single-level call/return; hand-written sequences cover nested
// calls to overflow, underflow, flag clearing and reset during a call chain.
module tb_pc_stack;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pc_stack_if #(.AW(8), .SPW(3)) bus ();

  pc_stack #(.AW(8), .DEPTH(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       rst, pcen, load, call, ret, clr;
    logic [7:0] in_addr;
    logic [7:0] a;
    logic [2:0] sp;
    logic       halt, full, empty, ovf, unf;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one set of commands for one clock, then sample 1 time unit later.
  task automatic cycle(input logic r, input logic p, input logic l, input logic c,
                       input logic rt, input logic cl, input logic [7:0] in_addr);
    reset       = r;
    bus.pcen    = p;
    bus.load    = l;
    bus.call    = c;
    bus.ret     = rt;
    bus.clr_err = cl;
    bus.in_addr = in_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [7:0] a, input logic [2:0] sp,
                              input logic halt, input logic full, input logic empty,
                              input logic ovf, input logic unf);
    check({tag, ".a"},     32'(bus.a),     32'(a));
    check({tag, ".sp"},    32'(bus.sp),    32'(sp));
    check({tag, ".halt"},  32'(bus.halt),  32'(halt));
    check({tag, ".full"},  32'(bus.full),  32'(full));
    check({tag, ".empty"}, 32'(bus.empty), 32'(empty));
    check({tag, ".ovf"},   32'(bus.ovf),   32'(ovf));
    check({tag, ".unf"},   32'(bus.unf),   32'(unf));
  endtask

  vec_t vecs [18];

  initial begin
    //            rst pcen load call ret clr  in      a      sp    halt full empty ovf unf
    vecs[0]  = '{H, L, L, L, L, L, 8'h00, 8'h00, 3'd0, L, L, H, L, L}; // reset
    vecs[1]  = '{L, H, L, L, L, L, 8'h00, 8'h01, 3'd0, L, L, H, L, L};
    vecs[2]  = '{L, H, L, L, L, L, 8'h00, 8'h02, 3'd0, L, L, H, L, L};
    vecs[3]  = '{L, H, L, L, L, L, 8'h00, 8'h03, 3'd0, L, L, H, L, L};
    vecs[4]  = '{L, L, H, L, L, L, 8'hFD, 8'hFD, 3'd0, L, L, H, L, L}; // jump near top
    vecs[5]  = '{L, H, L, L, L, L, 8'h00, 8'hFE, 3'd0, L, L, H, L, L};
    vecs[6]  = '{L, H, L, L, L, L, 8'h00, 8'hFF, 3'd0, H, L, H, L, L};
    vecs[7]  = '{L, H, L, L, L, L, 8'h00, 8'hFF, 3'd0, H, L, H, L, L}; // saturates
    vecs[8]  = '{L, H, L, L, L, L, 8'h00, 8'hFF, 3'd0, H, L, H, L, L};
    vecs[9]  = '{L, H, H, L, L, L, 8'h20, 8'h20, 3'd0, L, L, H, L, L}; // load beats pcen, from halt
    vecs[10] = '{L, L, H, L, L, L, 8'h10, 8'h10, 3'd0, L, L, H, L, L};
    vecs[11] = '{L, H, L, H, L, L, 8'h80, 8'h80, 3'd1, L, L, L, L, L}; // call beats pcen, push 0x11
    vecs[12] = '{L, H, L, L, L, L, 8'h00, 8'h81, 3'd1, L, L, L, L, L};
    vecs[13] = '{L, H, L, L, L, L, 8'h00, 8'h82, 3'd1, L, L, L, L, L};
    vecs[14] = '{L, H, H, L, H, L, 8'h55, 8'h11, 3'd0, L, L, H, L, L}; // ret beats load/pcen
    vecs[15] = '{L, L, H, L, L, L, 8'hFF, 8'hFF, 3'd0, H, L, H, L, L};
    vecs[16] = '{L, L, L, H, L, L, 8'h40, 8'h40, 3'd1, L, L, L, L, L}; // push wraps to 0x00
    vecs[17] = '{L, L, L, L, H, L, 8'h00, 8'h00, 3'd0, L, L, H, L, L};

    cycle(H, L, L, L, L, L, 8'h00);

    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].rst, vecs[i].pcen, vecs[i].load, vecs[i].call,
            vecs[i].ret, vecs[i].clr, vecs[i].in_addr);
      expect_state($sformatf("vec%0d", i), vecs[i].a, vecs[i].sp, vecs[i].halt,
                   vecs[i].full, vecs[i].empty, vecs[i].ovf, vecs[i].unf);
    end

    // Nested calls to full, overflow, then unwind.
    cycle(L, L, H, L, L, L, 8'h01);
    cycle(L, L, L, H, L, L, 8'h30);                 // push 0x02
    cycle(L, H, L, L, L, L, 8'h00);                 // 0x31
    cycle(L, L, L, H, L, L, 8'h40);                 // push 0x32
    cycle(L, H, L, L, L, L, 8'h00);                 // 0x41
    cycle(L, L, L, H, L, L, 8'h50);                 // push 0x42
    cycle(L, H, L, L, L, L, 8'h00);                 // 0x51
    cycle(L, L, L, H, L, L, 8'h60);                 // push 0x52
    expect_state("nest_full", 8'h60, 3'd4, L, H, L, L, L);
    cycle(L, L, L, H, L, L, 8'h70);
    expect_state("overflow", 8'h60, 3'd4, L, H, L, H, L);
    cycle(L, L, L, L, H, L, 8'h00);
    expect_state("ret1", 8'h52, 3'd3, L, L, L, H, L);
    cycle(L, L, L, L, H, L, 8'h00);
    expect_state("ret2", 8'h42, 3'd2, L, L, L, H, L);
    cycle(L, L, L, L, H, L, 8'h00);
    expect_state("ret3", 8'h32, 3'd1, L, L, L, H, L);
    cycle(L, L, L, L, H, L, 8'h00);
    expect_state("ret4", 8'h02, 3'd0, L, L, H, H, L);

    // Underflow, clear, and set-beats-clear.
    cycle(L, L, L, L, H, L, 8'h00);
    expect_state("underflow", 8'h02, 3'd0, L, L, H, H, H);
    cycle(L, L, L, L, L, H, 8'h00);
    expect_state("clr_err", 8'h02, 3'd0, L, L, H, L, L);
    cycle(L, L, L, L, H, H, 8'h00);
    expect_state("unf_set_wins", 8'h02, 3'd0, L, L, H, L, H);
    cycle(L, L, L, L, L, H, 8'h00);
    expect_state("clr_err2", 8'h02, 3'd0, L, L, H, L, L);

    // call and ret together with one entry: pop only.
    cycle(L, L, L, H, L, L, 8'h90);                 // push 0x03
    expect_state("call_sp1", 8'h90, 3'd1, L, L, L, L, L);
    cycle(L, L, L, H, H, L, 8'hA5);
    expect_state("call_ret", 8'h03, 3'd0, L, L, H, L, L);
    cycle(L, L, L, L, H, L, 8'h00);                 // nothing was pushed
    expect_state("no_push", 8'h03, 3'd0, L, L, H, L, H);

    // Reset in the middle of a call chain, with unf still set.
    cycle(L, L, H, L, L, L, 8'h10);
    cycle(L, L, L, H, L, L, 8'h20);
    cycle(L, L, L, H, L, L, 8'h30);
    expect_state("pre_reset", 8'h30, 3'd2, L, L, L, L, H);
    cycle(H, H, L, H, L, H, 8'h99);
    expect_state("reset_call", 8'h00, 3'd0, L, L, H, L, L);
    cycle(L, L, L, L, H, L, 8'h00);
    expect_state("post_reset_ret", 8'h00, 3'd0, L, L, H, L, H);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
